// File: rtl/multicam_capture.sv
// multicam_capture: N-channel camera capture engine. Each channel oversamples its
// camera port in the sysclk domain, writes the full frame to a display RAM and a
// row window to a calc RAM, and the channels are paired into frame sets.
module multicam_capture #(
  parameter int N_CAM     = 2,
  parameter int PIX_W     = 3,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 240,
  parameter int ADDR_W    = 16,
  parameter int CALC_ROW  = 116,
  parameter int CALC_ROWS = 8,
  parameter int CALC_AW   = 11
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     arm,
  input  logic [N_CAM-1:0]         pclk,
  input  logic [N_CAM-1:0]         vsync,
  input  logic [N_CAM-1:0]         href,
  input  logic [N_CAM*PIX_W-1:0]   d,
  output logic [N_CAM*PIX_W-1:0]   data,
  output logic [N_CAM*ADDR_W-1:0]  wraddr,
  output logic [N_CAM-1:0]         wren,
  output logic [N_CAM*PIX_W-1:0]   data_calc,
  output logic [N_CAM*CALC_AW-1:0] wraddr_calc,
  output logic [N_CAM-1:0]         wren_calc,
  output logic [N_CAM-1:0]         frame_done,
  output logic                     pair_ready,
  output logic                     skew_err,
  output logic [N_CAM-1:0]         short_err
);

  // Column counter needs one extra bit so it can park at IMG_W; row parks at IMG_H.
  localparam int COL_W = $clog2(IMG_W) + 1;
  localparam int ROW_W = $clog2(IMG_H + 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPT, DONE} state_t;

  function automatic logic [ROW_W-1:0] row_sat_inc(input logic [ROW_W-1:0] r);
    if (int'(r) >= IMG_H) return r;
    return r + 1'b1;
  endfunction

  function automatic logic [COL_W-1:0] col_sat_inc(input logic [COL_W-1:0] c);
    if (int'(c) >= IMG_W) return c;
    return c + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] disp_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'(int'(r) * IMG_W + int'(c));
  endfunction

  function automatic logic in_calc(input logic [ROW_W-1:0] r);
    return (int'(r) >= CALC_ROW) && (int'(r) < CALC_ROW + CALC_ROWS);
  endfunction

  function automatic logic [CALC_AW-1:0] calc_addr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
    return CALC_AW'((int'(r) - CALC_ROW) * IMG_W + int'(c));
  endfunction

  logic [N_CAM-1:0]       pclk_p0, pclk_p1, pclk_p2;
  logic [N_CAM-1:0]       vsync_p0, vsync_p1, vsync_p2;
  logic [N_CAM-1:0]       href_p0, href_p1, href_p2;
  logic [N_CAM*PIX_W-1:0] d_p0, d_p1;
  logic [N_CAM-1:0]       pe, hf, vr, vf;
  logic [N_CAM-1:0]       fd;

  // Stage p0/p1: two-flop synchronisers; p2 keeps the previous synced level for edge detection
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pclk_p0  <= '0; pclk_p1  <= '0; pclk_p2  <= '0;
      vsync_p0 <= '0; vsync_p1 <= '0; vsync_p2 <= '0;
      href_p0  <= '0; href_p1  <= '0; href_p2  <= '0;
    end else begin
      pclk_p0  <= pclk;  pclk_p1  <= pclk_p0;  pclk_p2  <= pclk_p1;
      vsync_p0 <= vsync; vsync_p1 <= vsync_p0; vsync_p2 <= vsync_p1;
      href_p0  <= href;  href_p1  <= href_p0;  href_p2  <= href_p1;
    end
  end

  // Pixel data synchroniser, aligned with the pclk synchroniser
  always_ff @(posedge sysclk) begin
    d_p0 <= d;
    d_p1 <= d_p0;
  end

  assign pe = pclk_p1 & ~pclk_p2;
  assign hf = ~href_p1 & href_p2;
  assign vr = vsync_p1 & ~vsync_p2;
  assign vf = ~vsync_p1 & vsync_p2;

  for (genvar i = 0; i < N_CAM; i++) begin : g_ch
    state_t             st, st_n;
    logic               done_evt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               vld_p3, calc_vld_p3;
    logic [PIX_W-1:0]   pix_p3;
    logic [ADDR_W-1:0]  addr_p3;
    logic [CALC_AW-1:0] caddr_p3;
    logic               fd_q, short_q;

    // Channel state register
    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) st <= IDLE;
      else       st <= st_n;
    end

    // Next state: arm, start on vsync fall, finish on vsync rise
    always_comb begin
      st_n     = st;
      done_evt = 1'b0;
      case (st)
        IDLE:    if (mode || arm) st_n = ARMED;
        ARMED:   if (vf[i]) st_n = CAPT;
        CAPT:    if (vr[i]) begin
                   st_n     = DONE;
                   done_evt = 1'b1;
                 end
        DONE:    if (mode || arm) st_n = ARMED;
        default: st_n = IDLE;
      endcase
    end

    // Stage p3: pixel/line counters and RAM write strobes, one cycle after the pclk edge
    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        col         <= '0;
        row         <= '0;
        vld_p3      <= 1'b0;
        calc_vld_p3 <= 1'b0;
        pix_p3      <= '0;
        addr_p3     <= '0;
        caddr_p3    <= '0;
        fd_q        <= 1'b0;
        short_q     <= 1'b0;
      end else begin
        vld_p3      <= 1'b0;
        calc_vld_p3 <= 1'b0;
        fd_q        <= done_evt;
        if (st == ARMED && vf[i]) begin
          col <= '0;
          row <= '0;
        end
        if (st == CAPT) begin
          if (hf[i]) begin
            col <= '0;
            row <= row_sat_inc(row);
          end else if (pe[i] && href_p1[i]) begin
            col <= col_sat_inc(col);
            if (int'(col) < IMG_W && int'(row) < IMG_H) begin
              vld_p3  <= 1'b1;
              pix_p3  <= d_p1[i*PIX_W +: PIX_W];
              addr_p3 <= disp_addr(row, col);
              if (in_calc(row)) begin
                calc_vld_p3 <= 1'b1;
                caddr_p3    <= calc_addr(row, col);
              end
            end
          end
          if (done_evt && int'(row) < IMG_H) short_q <= 1'b1;
        end
      end
    end

    assign data[i*PIX_W +: PIX_W]          = pix_p3;
    assign wraddr[i*ADDR_W +: ADDR_W]      = addr_p3;
    assign wren[i]                         = vld_p3;
    assign data_calc[i*PIX_W +: PIX_W]     = pix_p3;
    assign wraddr_calc[i*CALC_AW +: CALC_AW] = caddr_p3;
    assign wren_calc[i]                    = calc_vld_p3;
    assign fd[i]                           = fd_q;
    assign short_err[i]                    = short_q;
  end

  assign frame_done = fd;

  logic [N_CAM-1:0] got;
  logic             pair_q, skew_q;

  // Pairing: collect one frame per channel; a repeat before the pair closes is a skew error
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      got    <= '0;
      pair_q <= 1'b0;
      skew_q <= 1'b0;
    end else if (mode) begin
      if (&got) begin
        pair_q <= 1'b1;
        got    <= fd;
      end else begin
        pair_q <= 1'b0;
        got    <= got | fd;
        if (|(fd & got)) skew_q <= 1'b1;
      end
    end else begin
      if (arm) begin
        pair_q <= 1'b0;
        got    <= fd;
      end else begin
        got <= got | fd;
        if (&got) pair_q <= 1'b1;
        if (|(fd & got)) skew_q <= 1'b1;
      end
    end
  end

  assign pair_ready = pair_q;
  assign skew_err   = skew_q;

endmodule
